// File: rtl/clk_div_pkg.sv
// Shared widths, FSM encoding and helpers for the clock divider family.
// The ratio meter uses the period counter width and its saturation limit.
package clk_div_pkg;

    localparam int DIV_W = 8;
    localparam int PER_W = 9;
    localparam logic [PER_W-1:0] PER_MAX = 9'd256;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } meter_state_e;

    function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
        return (v == PER_MAX) ? PER_MAX : v + 9'd1;
    endfunction

endpackage

// File: rtl/clock_ratio_meter_if.sv
// Measurement bus of the clock ratio meter: the clock under test in, results out.
interface clock_ratio_meter_if;
    import clk_div_pkg::*;

    logic             clk_in;
    logic [DIV_W-1:0] divide_out;
    logic [DIV_W-1:0] high_out;
    logic             meas_valid;
    logic             locked;
    logic             no_clock;

    modport master (
        input  clk_in,
        output divide_out,
        output high_out,
        output meas_valid,
        output locked,
        output no_clock
    );

    modport slave (
        output clk_in,
        input  divide_out,
        input  high_out,
        input  meas_valid,
        input  locked,
        input  no_clock
    );

endinterface

// File: rtl/clk_edge_sync.sv
// Synchronizes an asynchronous clock-like input and flags its rising edges.
// rise is high for one cycle when the synced level goes 0 -> 1.
module clk_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic synced,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // next state of the synchronizer chain and the history flop
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // synchronizer and history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures a divided clock against clk: period-1 (divide setting), high time,
// lock after LOCK_COUNT identical periods, and a no-clock flag after 257 idle cycles.
module clock_ratio_meter
    import clk_div_pkg::*;
#(
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    clock_ratio_meter_if.master bus
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    logic             synced_s;
    logic             rise_s;
    logic             timeout_s;
    logic [3:0]       match_inc_s;

    meter_state_e     state_q;
    meter_state_e     state_d;
    logic [PER_W-1:0] per_cnt_q;
    logic [PER_W-1:0] per_cnt_d;
    logic [PER_W-1:0] hi_acc_q;
    logic [PER_W-1:0] hi_acc_d;
    logic [3:0]       match_cnt_q;
    logic [3:0]       match_cnt_d;
    logic [DIV_W-1:0] divide_q;
    logic [DIV_W-1:0] divide_d;
    logic [DIV_W-1:0] high_q;
    logic [DIV_W-1:0] high_d;
    logic             meas_valid_q;
    logic             meas_valid_d;
    logic             locked_q;
    logic             locked_d;
    logic             no_clock_q;
    logic             no_clock_d;

    clk_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.clk_in),
        .synced(synced_s),
        .rise  (rise_s)
    );

    // counters, measurement capture, lock tracking and timeout
    always_comb begin
        state_d      = state_q;
        per_cnt_d    = rise_s ? {PER_W{1'b0}} : sat_inc(per_cnt_q);
        match_cnt_d  = match_cnt_q;
        divide_d     = divide_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        no_clock_d   = no_clock_q;

        // the edge cycle itself is high, so a new period starts with one high cycle
        if (rise_s) begin
            hi_acc_d = 9'd1;
        end else if (synced_s) begin
            hi_acc_d = sat_inc(hi_acc_q);
        end else begin
            hi_acc_d = hi_acc_q;
        end

        match_inc_s = (match_cnt_q >= LOCK_TARGET) ? LOCK_TARGET : match_cnt_q + 4'd1;
        // fires once, as per_cnt steps onto its saturation value
        timeout_s   = ~rise_s & (per_cnt_q == (PER_MAX - 9'd1));

        if (timeout_s) begin
            state_d     = IDLE;
            no_clock_d  = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = 4'd0;
        end else if (rise_s) begin
            case (state_q)
                IDLE: begin
                    state_d    = TRACK;
                    no_clock_d = 1'b0;
                end
                TRACK: begin
                    divide_d     = per_cnt_q[DIV_W-1:0];
                    high_d       = hi_acc_q[DIV_W-1:0];
                    meas_valid_d = 1'b1;
                    if (per_cnt_q[DIV_W-1:0] == divide_q) begin
                        match_cnt_d = match_inc_s;
                        locked_d    = (match_inc_s == LOCK_TARGET);
                    end else begin
                        match_cnt_d = 4'd1;
                        locked_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            per_cnt_q    <= {PER_W{1'b0}};
            hi_acc_q     <= {PER_W{1'b0}};
            match_cnt_q  <= 4'd0;
            divide_q     <= {DIV_W{1'b0}};
            high_q       <= {DIV_W{1'b0}};
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            no_clock_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            hi_acc_q     <= hi_acc_d;
            match_cnt_q  <= match_cnt_d;
            divide_q     <= divide_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            no_clock_q   <= no_clock_d;
        end
    end

    assign bus.divide_out = divide_q;
    assign bus.high_out   = high_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.locked     = locked_q;
    assign bus.no_clock   = no_clock_q;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Bench for clock_ratio_meter: a divider-like stimulus generator plus a timestamp
// reference model that predicts every output on every cycle.
module tb_clock_ratio_meter;

    localparam int LC = 4;

    logic clk      = 1'b0;
    logic clk_skew = 1'b0;
    logic rst;
    logic drv_in;
    logic pt_en;

    clock_ratio_meter_if mif();
    assign mif.clk_in = pt_en ? clk_skew : drv_in;

    clock_ratio_meter #(
        .LOCK_COUNT (LC),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(mif)
    );

    initial forever #5 clk = ~clk;
    // same-frequency copy of clk with a fixed skew: every clk edge samples it at one level
    initial begin
        #2;
        forever #5 clk_skew = ~clk_skew;
    end

    typedef struct {
        int t;
        bit mv;
        int dv;
        int hi;
        bit lk;
        bit nc;
    } ev_t;

    typedef struct {
        int dv;
        int hi;
        int nper;
        int x_div;
        int x_high;
        bit x_lk;
    } vec_t;

    ev_t evq[$];
    int  cyc, errors, checks;
    bit  in_rst, rel_pending;
    int  mv_count, last_mv_cyc;

    // reference model: edge timestamps and high-cycle counts in drive time
    bit  prev_in, armed;
    int  last_rise, hi_cnt, match, m_div, m_high;
    bit  m_lk, m_nc;
    int  e_div, e_high;
    bit  e_mv, e_lk, e_nc;

    // stimulus generator: 0 divider waveform, 1 constant level, 2 pass-through
    int  g_mode, g_per, g_high, g_ph;
    bit  g_lvl;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, got, want);
        end
    endtask

    function automatic int pack(input logic [7:0] d, input logic [7:0] h,
                                input logic mv, input logic lk, input logic nc);
        return {13'd0, d, h, mv, lk, nc};
    endfunction

    function automatic int dut_outs();
        return pack(mif.divide_out, mif.high_out, mif.meas_valid, mif.locked, mif.no_clock);
    endfunction

    task automatic model_push(input int t, input bit mv);
        ev_t e;
        e.t = t; e.mv = mv; e.dv = m_div; e.hi = m_high; e.lk = m_lk; e.nc = m_nc;
        evq.push_back(e);
    endtask

    task automatic model_reset(input int r);
        evq.delete();
        prev_in = 1'b0; armed = 1'b0; last_rise = r - 3; hi_cnt = 0; match = 0;
        m_div = 0; m_high = 0; m_lk = 1'b0; m_nc = 1'b0;
        e_div = 0; e_high = 0; e_mv = 1'b0; e_lk = 1'b0; e_nc = 1'b0;
    endtask

    // a rise driven at step c is measured 3 steps later; a gap over 256 is a timeout
    task automatic model_drive(input bit v);
        int per;
        if (cyc == last_rise + 257) begin
            armed = 1'b0; match = 0; m_lk = 1'b0; m_nc = 1'b1;
            model_push(cyc + 2, 1'b0);
        end
        if (v && !prev_in) begin
            if (armed) begin
                per = cyc - last_rise;
                if (per - 1 == m_div) match = (match >= LC) ? LC : match + 1;
                else                  match = 1;
                m_lk = (match == LC);
                m_div = per - 1;
                m_high = hi_cnt;
                model_push(cyc + 3, 1'b1);
            end else begin
                armed = 1'b1; m_nc = 1'b0;
                model_push(cyc + 3, 1'b0);
            end
            last_rise = cyc;
            hi_cnt = 1;
        end else if (v) begin
            hi_cnt++;
        end
        prev_in = v;
    endtask

    task automatic step();
        ev_t ev;
        bit  v;
        @(negedge clk);
        cyc++;
        e_mv = 1'b0;
        while (evq.size() > 0 && evq[0].t <= cyc) begin
            ev = evq.pop_front();
            e_mv = ev.mv; e_div = ev.dv; e_high = ev.hi; e_lk = ev.lk; e_nc = ev.nc;
        end
        check("outputs{div,high,mv,lk,nc}", dut_outs(),
              pack(e_div[7:0], e_high[7:0], e_mv, e_lk, e_nc));
        if (mif.meas_valid) begin
            mv_count++;
            last_mv_cyc = cyc;
        end
        if (rel_pending) begin
            rst = 1'b0; rel_pending = 1'b0; in_rst = 1'b0;
            model_reset(cyc);
        end
        if (!in_rst) begin
            case (g_mode)
                0: begin
                    v = (g_ph < g_high);
                    g_ph = (g_ph + 1 >= g_per) ? 0 : g_ph + 1;
                end
                1:       v = g_lvl;
                default: v = 1'b0;
            endcase
            pt_en  = (g_mode == 2);
            drv_in = (g_mode == 2) ? 1'b0 : v;
            model_drive(v);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_div(input int d, input int h);
        g_mode = 0; g_per = d + 1; g_high = h; g_ph = 0;
    endtask

    task automatic wait_mv(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (mif.meas_valid) seen = 1'b1;
        end
    endtask

    task automatic async_reset(input int hold);
        @(posedge clk);
        #2;
        rst = 1'b1; in_rst = 1'b1; drv_in = 1'b0; pt_en = 1'b0; g_ph = 0;
        model_reset(cyc);
        #1;
        check("async_reset_outputs", dut_outs(), 0);
        run(hold);
        rel_pending = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        bit   seen, found;
        int   t0, mvb, d, h, r;

        tbl[0] = '{3,   2,   8,  3,   2,   1'b1};
        tbl[1] = '{1,   1,   10, 1,   1,   1'b1};
        tbl[2] = '{4,   3,   8,  4,   3,   1'b1};
        tbl[3] = '{4,   2,   8,  4,   2,   1'b1};
        tbl[4] = '{255, 128, 7,  255, 128, 1'b1};
        tbl[5] = '{10,  5,   8,  10,  5,   1'b1};

        cyc = 0; errors = 0; checks = 0; mv_count = 0; last_mv_cyc = 0;
        g_mode = 1; g_lvl = 1'b0; g_per = 2; g_high = 1; g_ph = 0;
        drv_in = 1'b0; pt_en = 1'b0; rst = 1'b1; in_rst = 1'b1; rel_pending = 1'b0;
        model_reset(0);
        run(3);
        rel_pending = 1'b1;
        step();
        step();
        check("reset_state", dut_outs(), 0);

        // table of steady divide settings
        for (int k = 0; k < 6; k++) begin
            set_div(tbl[k].dv, tbl[k].hi);
            run(tbl[k].nper * (tbl[k].dv + 1));
            check("tbl_divide", int'(mif.divide_out), tbl[k].x_div);
            check("tbl_high", int'(mif.high_out), tbl[k].x_high);
            check("tbl_locked", int'(mif.locked), int'(tbl[k].x_lk));
            check("tbl_no_clock", int'(mif.no_clock), 0);
        end

        // divide 3 -> 7 while locked
        set_div(3, 2);
        run(40);
        wait_mv(20, seen);
        t0 = cyc;
        wait_mv(20, seen);
        check("mv_spacing_div3", cyc - t0, 4);
        check("locked_div3", int'(mif.locked), 1);
        set_div(7, 4);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (mif.meas_valid && mif.divide_out == 8'd7) found = 1'b1;
        end
        check("first_div7_seen", int'(found), 1);
        check("lock_drop_with_mv", int'(mif.locked), 0);
        run(80);
        check("relock_div7", int'(mif.locked), 1);
        check("high_div7", int'(mif.high_out), 4);

        // input stuck low after lock
        set_div(3, 2);
        run(40);
        g_mode = 1; g_lvl = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (mif.no_clock) found = 1'b1;
        end
        check("noclk_seen", int'(found), 1);
        check("noclk_delay", cyc - last_mv_cyc, 256);
        check("noclk_unlocked", int'(mif.locked), 0);
        check("noclk_div_hold", int'(mif.divide_out), 3);
        set_div(3, 2);
        mvb = mv_count;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (!mif.no_clock) found = 1'b1;
        end
        check("noclk_clear", int'(found), 1);
        check("rearm_no_mv", mv_count - mvb, 0);
        wait_mv(30, seen);
        check("rearm_mv_seen", int'(seen), 1);
        check("rearm_divide", int'(mif.divide_out), 3);

        // pass-through clock: never sampled as toggling
        g_mode = 2;
        run(10);
        mvb = mv_count;
        run(290);
        check("pt_no_mv", mv_count - mvb, 0);
        check("pt_no_clock", int'(mif.no_clock), 1);

        // reset mid-period while locked
        set_div(3, 2);
        run(60);
        check("pre_reset_locked", int'(mif.locked), 1);
        run(1);
        async_reset(3);
        t0 = cyc;
        wait_mv(30, seen);
        check("post_reset_mv_seen", int'(seen), 1);
        check("post_reset_first_mv_delay", cyc - t0, 7);
        check("post_reset_divide", int'(mif.divide_out), 3);
        check("post_reset_high", int'(mif.high_out), 2);

        // randomized settings, stalls and switches
        for (int k = 0; k < 15; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                g_mode = 1;
                g_lvl = 1'($urandom_range(0, 1));
                run($urandom_range(100, 400));
            end else begin
                d = (r < 2) ? $urandom_range(1, 255) : $urandom_range(1, 16);
                h = $urandom_range(1, d);
                set_div(d, h);
                run($urandom_range(2, 7) * (d + 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
